jtag_tap: RTL and testbench
===========================

// Module: jtag_tap
//
// PURPOSE
//   Parametrised IEEE 1149.1 TAP controller: full 16-state FSM, IR_WIDTH-bit
//   instruction register, and three data registers (IDCODE, BYPASS, USER).
//   Next-generation JTAG front end: IDCODE shifted from a generic DR shift
//   register instead of a fixed byte transmitter. The USER DR gives the
//   design a parallel capture/update window into on-chip logic.
//
// PARAMETERS
//   IR_WIDTH     4              instruction register length, >= 2
//   DR_WIDTH     8              USER data register length, >= 1
//   IDCODE_VAL   32'h000F_AF01  IDCODE DR capture value; bit 0 must be 1
//   INSTR_IDCODE 4'b1110        IDCODE opcode, IR_WIDTH bits
//   INSTR_USER   4'b1010        USER DR opcode, IR_WIDTH bits
//                               BYPASS is fixed at all-ones
//
// PORTS
//   clk_tck         in   1         TCK; sole clock, all logic on posedge
//   reset           in   1         synchronous, active-high reset
//   enable          in   1         clock qualifier; 0 = every register holds
//   tms             in   1         test mode select, sampled on posedge
//   tdi             in   1         test data in, sampled on posedge
//   tdo             out  1         test data out (combinational from shift LSB)
//   tdo_oe          out  1         1 while in ShiftIr or ShiftDr
//   ir_value        out  IR_WIDTH  active instruction
//   user_dr_in      in   DR_WIDTH  parallel value captured in CaptureDr (USER)
//   user_dr_out     out  DR_WIDTH  value latched in UpdateDr (USER)
//   user_dr_update  out  1         one-cycle pulse when user_dr_out is written
//
// BEHAVIOUR
//   - Reset values: state TestLogicReset, ir_value=INSTR_IDCODE, user_dr_out=0,
//     tdo=0, tdo_oe=0, user_dr_update=0, all shift registers 0.
//   - Reset wins over enable. Reset mid-scan aborts the scan: no update occurs.
//   - enable=0: state, IR, shift registers and user_dr_out hold.
//     user_dr_update is forced to 0.
//   - FSM: standard 1149.1 transitions on tms, one transition per enabled edge.
//     No data-dependent exits: ShiftDr leaves only on tms=1.
//     Five enabled edges with tms=1 reach TestLogicReset from any state.
//   - In TestLogicReset: ir_value <= INSTR_IDCODE every enabled cycle.
//   - CaptureIr: ir_shift <= {IR_WIDTH-2 zeros, 2'b01}.
//   - ShiftIr: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}. tdo = ir_shift[0].
//   - UpdateIr: ir_value <= ir_shift. The IR changes only here or in TestLogicReset.
//   - DR select is decoded from ir_value:
//       INSTR_IDCODE -> 32-bit register
//       INSTR_USER   -> DR_WIDTH register
//       anything else, including 4'b1000 ABORT -> 1-bit BYPASS
//   - CaptureDr loads the selected register:
//       IDCODE -> IDCODE_VAL, USER -> user_dr_in, BYPASS -> 0.
//   - ShiftDr: LSB-first shift, tdi enters at the MSB of the selected register.
//     tdo = bit 0 of the selected register.
//   - UpdateDr with USER selected: user_dr_out <= user_shift, and user_dr_update
//     is high during the following cycle only. No pulse for other instructions.
//   - Exit1/Pause/Exit2 states hold shift contents. Exit2->Shift resumes the scan.
//   - tdo=0 whenever tdo_oe=0.
//   - Latency: a bit is visible on tdo in the cycle it reaches position 0.
//     The host samples before the next posedge.
//
// STRUCTURE
//   - jtag_pkg holds tap_state_t (4-bit enum with the 16 states, encodings 0..15),
//     the BYPASS/ABORT opcodes and the IDCODE length (32).
//   - Sub-module jtag_tap_fsm: inputs clk_tck, reset, enable, tms.
//     Outputs the state plus one-hot decodes (capture_ir, shift_ir, update_ir,
//     capture_dr, shift_dr, update_dr, in_reset).
//   - jtag_tap holds the IR, the DR shift registers, the DR mux and the tdo mux.
//
// TESTING
//   1. reset=1 then 0, with tms=1 for 5 edges:
//      -> state TestLogicReset, ir_value=4'b1110, tdo_oe=0, tdo=0.
//   2. Default IR, scan 32 DR bits:
//      -> tdo sequence LSB-first equals 32'h000F_AF01; first bit 1.
//   3. Load IR 4'b1111 (BYPASS), then shift DR tdi=1,0,1,1:
//      -> tdo=0,1,0,1, i.e. one-cycle delay.
//      During the IR scan, tdo shows captured 01 in the first two bits.
//   4. IR=4'b1010, user_dr_in=8'h5A; shift in 8'hC3, then UpdateDr:
//      -> tdo yields 8'h5A LSB-first, user_dr_out=8'hC3, user_dr_update high
//         exactly 1 cycle.
//   5. USER scan paused mid-shift (PauseDr 3 cycles, enable=0 for 2 cycles),
//      then resumed:
//      -> shift contents preserved, final user_dr_out correct.
//   6. reset asserted during ShiftDr of a USER scan:
//      -> TestLogicReset, user_dr_out stays at its previous value,
//         no user_dr_update pulse, ir_value=4'b1110.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP front end.
//   tap_state_t : the 16 IEEE 1149.1 TAP controller states, encodings 0..15
//   dr_sel_t    : which data register the active instruction routes to TDI/TDO
//   IDCODE_LEN  : length of the IDCODE data register
//   INSTR_BYPASS / INSTR_ABORT : fixed 4-bit opcodes that always decode to BYPASS
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_t;

  localparam int         IDCODE_LEN   = 32;
  localparam logic [3:0] INSTR_BYPASS = 4'b1111;
  localparam logic [3:0] INSTR_ABORT  = 4'b1000;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
//   clk_tck    in  : TCK, all state changes on posedge
//   reset      in  : synchronous active-high, forces TEST_LOGIC_RESET
//   enable     in  : clock qualifier, 0 = state holds
//   tms        in  : test mode select
//   state      out : current TAP state (also the debug view of the FSM)
//   capture_ir, shift_ir, update_ir,
//   capture_dr, shift_dr, update_dr,
//   in_reset   out : one-hot decodes of the current state
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk_tck,
  input  logic       reset,
  input  logic       enable,
  input  logic       tms,
  output tap_state_t state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       in_reset
);

  tap_state_t state_next;

  always_ff @(posedge clk_tck) begin
    if (reset) begin
      state <= TEST_LOGIC_RESET;
    end else if (enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    capture_ir = (state == CAPTURE_IR);
    shift_ir   = (state == SHIFT_IR);
    update_ir  = (state == UPDATE_IR);
    capture_dr = (state == CAPTURE_DR);
    shift_dr   = (state == SHIFT_DR);
    update_dr  = (state == UPDATE_DR);
    in_reset   = (state == TEST_LOGIC_RESET);
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP: FSM, instruction register and IDCODE / USER / BYPASS data registers.
//   clk_tck        in  : TCK, sole clock
//   reset          in  : synchronous active-high reset (wins over enable)
//   enable         in  : clock qualifier, 0 = every register holds
//   tms, tdi       in  : serial control and data, sampled on posedge
//   tdo            out : serial data, LSB of the shifting register, 0 when idle
//   tdo_oe         out : 1 in SHIFT_IR / SHIFT_DR
//   ir_value       out : active instruction
//   user_dr_in     in  : parallel value captured into the USER DR
//   user_dr_out    out : value latched from the USER DR in UPDATE_DR
//   user_dr_update out : one-cycle pulse after user_dr_out is written
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  DR_WIDTH     = 8,
  parameter logic [31:0]         IDCODE_VAL   = 32'h000F_AF01,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 4'b1110,
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = 4'b1010
) (
  input  logic                clk_tck,
  input  logic                reset,
  input  logic                enable,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_dr_update
);

  // Mandatory IR capture pattern: ...0001, so the host sees 1 then 0 first.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t tap_state;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr, in_reset;

  logic [IR_WIDTH-1:0]   ir_shift;
  logic [IDCODE_LEN-1:0] idcode_shift;
  logic [DR_WIDTH-1:0]   user_shift;
  logic                  bypass_bit;
  logic                  upd_q;
  dr_sel_t               dr_sel;

  jtag_tap_fsm u_fsm (
    .clk_tck    (clk_tck),
    .reset      (reset),
    .enable     (enable),
    .tms        (tms),
    .state      (tap_state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .in_reset   (in_reset)
  );

  // Unknown opcodes (ABORT included) fall through to BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_value == INSTR_IDCODE) begin
      dr_sel = SEL_IDCODE;
    end else if (ir_value == INSTR_USER) begin
      dr_sel = SEL_USER;
    end
  end

  always_ff @(posedge clk_tck) begin
    if (reset) begin
      ir_value     <= INSTR_IDCODE;
      ir_shift     <= '0;
      idcode_shift <= '0;
      user_shift   <= '0;
      bypass_bit   <= 1'b0;
      user_dr_out  <= '0;
      upd_q        <= 1'b0;
    end else if (!enable) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= update_dr && (dr_sel == SEL_USER);

      if (in_reset) begin
        ir_value <= INSTR_IDCODE;
      end else if (update_ir) begin
        ir_value <= ir_shift;
      end

      if (capture_ir) begin
        ir_shift <= IR_CAPTURE;
      end else if (shift_ir) begin
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      end

      if (capture_dr) begin
        case (dr_sel)
          SEL_IDCODE: idcode_shift <= IDCODE_VAL;
          SEL_USER:   user_shift   <= user_dr_in;
          default:    bypass_bit   <= 1'b0;
        endcase
      end else if (shift_dr) begin
        case (dr_sel)
          SEL_IDCODE: idcode_shift <= {tdi, idcode_shift[IDCODE_LEN-1:1]};
          // Written as a shift/or so a 1-bit USER register stays legal.
          SEL_USER:   user_shift   <= (user_shift >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
          default:    bypass_bit   <= tdi;
        endcase
      end

      if (update_dr && (dr_sel == SEL_USER)) begin
        user_dr_out <= user_shift;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift[0];
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_IDCODE: tdo = idcode_shift[0];
        SEL_USER:   tdo = user_shift[0];
        default:    tdo = bypass_bit;
      endcase
    end
  end

  assign tdo_oe         = (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
  assign user_dr_update = upd_q & enable;

endmodule

// File: tb/tb_jtag_tap.sv
module tb_jtag_tap;

  logic       clk_tck = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b1;
  logic       tms     = 1'b1;
  logic       tdi     = 1'b0;
  logic [7:0] user_dr_in = 8'h00;
  logic       tdo, tdo_oe, user_dr_update;
  logic [3:0] ir_value;
  logic [7:0] user_dr_out;

  // ---------------- clock ----------------
  always #5 clk_tck = ~clk_tck;

  jtag_tap #(
    .IR_WIDTH     (4),
    .DR_WIDTH     (8),
    .IDCODE_VAL   (32'h000F_AF01),
    .INSTR_IDCODE (4'b1110),
    .INSTR_USER   (4'b1010)
  ) dut (
    .clk_tck        (clk_tck),
    .reset          (reset),
    .enable         (enable),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_oe         (tdo_oe),
    .ir_value       (ir_value),
    .user_dr_in     (user_dr_in),
    .user_dr_out    (user_dr_out),
    .user_dr_update (user_dr_update)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;
  logic last_tdo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // IEEE 1149.1 state graph as next-state tables indexed by state number.
  localparam int S_TLR = 0, S_CDR = 3, S_SDR = 4, S_UDR = 8;
  localparam int S_CIR = 10, S_SIR = 11, S_UIR = 15;
  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int         m_state = 0;
  logic [3:0] m_ir    = 4'b1110;
  logic [7:0] m_uout  = 8'h00;
  bit         m_upd   = 1'b0;
  bit         iq[$];   // IR shift contents, element 0 is next bit out
  bit         dq[$];   // selected DR contents, element 0 is next bit out

  function automatic int dr_len(input logic [3:0] ir);
    if (ir == 4'b1110) return 32;
    if (ir == 4'b1010) return 8;
    return 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [3:0] ir, input logic [7:0] uin);
    if (ir == 4'b1110) return 32'h000F_AF01;
    if (ir == 4'b1010) return {24'h0, uin};
    return 32'h0;
  endfunction

  always @(posedge clk_tck) begin : model
    logic [31:0] v;
    if (reset) begin
      m_state = S_TLR; m_ir = 4'b1110; m_uout = 8'h00; m_upd = 1'b0;
      iq.delete(); dq.delete();
    end else if (!enable) begin
      m_upd = 1'b0;
    end else begin
      m_upd = (m_state == S_UDR) && (m_ir == 4'b1010);
      case (m_state)
        S_TLR: m_ir = 4'b1110;
        S_CIR: begin
          iq.delete(); iq.push_back(1'b1);
          for (int i = 1; i < 4; i++) iq.push_back(1'b0);
        end
        S_SIR: begin void'(iq.pop_front()); iq.push_back(tdi); end
        S_UIR: for (int i = 0; i < 4; i++) m_ir[i] = iq[i];
        S_CDR: begin
          v = dr_cap(m_ir, user_dr_in);
          dq.delete();
          for (int i = 0; i < dr_len(m_ir); i++) dq.push_back(v[i]);
        end
        S_SDR: begin void'(dq.pop_front()); dq.push_back(tdi); end
        S_UDR: if (m_ir == 4'b1010) for (int i = 0; i < 8; i++) m_uout[i] = dq[i];
        default: ;
      endcase
      m_state = tms ? nx1[m_state] : nx0[m_state];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_tck) begin : compare
    logic exp_oe, exp_tdo;
    if (chk_en) begin
      exp_oe  = (m_state == S_SIR) || (m_state == S_SDR);
      exp_tdo = 1'b0;
      if (m_state == S_SIR && iq.size() > 0) exp_tdo = iq[0];
      if (m_state == S_SDR && dq.size() > 0) exp_tdo = dq[0];
      check("tdo", tdo, exp_tdo);
      check("tdo_oe", tdo_oe, exp_oe);
      check("ir_value", ir_value, m_ir);
      check("user_dr_out", user_dr_out, m_uout);
      check("user_dr_update", user_dr_update, m_upd & enable);
      if (user_dr_update) pulse_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tck(input logic t, input logic d);
    tms = t; tdi = d;
    @(negedge clk_tck); #1 last_tdo = tdo;
    @(posedge clk_tck); #1;
  endtask

  // From RunTestIdle: full IR scan ending back in RunTestIdle.
  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < 4; i++) begin
      tck(i == 3, v[i]); cap[i] = last_tdo;
    end
    tck(1, 0); tck(0, 0);
  endtask

  // From RunTestIdle: n-bit DR scan ending back in RunTestIdle.
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i]); dout[i] = last_tdo;
    end
    tck(1, 0); tck(0, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic [3:0]  cap;
    logic [31:0] dout;
    int          p0;

    // 1. reset then five tms=1 edges
    reset = 1'b1;
    tck(1, 0);
    chk_en = 1'b1;
    reset = 1'b0;
    repeat (5) tck(1, 0);
    check("t1_state", 32'(dut.tap_state), 32'd0);
    check("t1_ir", ir_value, 4'b1110);
    check("t1_tdo_oe", tdo_oe, 1'b0);
    check("t1_tdo", tdo, 1'b0);
    check("t1_user_out", user_dr_out, 8'h00);
    tck(0, 0);

    // 2. IDCODE scan
    scan_dr(32, 32'h1234_5678, dout);
    check("t2_idcode", dout, 32'h000F_AF01);
    check("t2_first_bit", dout[0], 1'b1);

    // 3. BYPASS
    p0 = pulse_cnt;
    load_ir(4'b1111, cap);
    check("t3_ir_capture", cap, 4'b0001);
    check("t3_ir", ir_value, 4'b1111);
    scan_dr(4, 32'b1101, dout);
    check("t3_bypass_tdo", dout[3:0], 4'b1010);
    tck(0, 0); tck(0, 0);
    check("t3_no_pulse", pulse_cnt - p0, 0);

    // 4. USER capture/update
    load_ir(4'b1010, cap);
    check("t4_ir", ir_value, 4'b1010);
    user_dr_in = 8'h5A;
    p0 = pulse_cnt;
    scan_dr(8, 32'hC3, dout);
    tck(0, 0); tck(0, 0);
    check("t4_capture", dout[7:0], 8'h5A);
    check("t4_user_out", user_dr_out, 8'hC3);
    check("t4_pulse_cycles", pulse_cnt - p0, 1);

    // 5. USER scan paused mid-shift, with enable dropped in PauseDr
    user_dr_in = 8'h3C;
    dout = 32'h0;
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < 4; i++) begin tck(i == 3, 8'hA6 >> i); dout[i] = last_tdo; end
    tck(0, 0); tck(0, 0); tck(0, 0);
    user_dr_in = 8'hFF;
    enable = 1'b0;
    tck(1, 1); tck(1, 1);
    enable = 1'b1;
    tck(1, 0); tck(0, 0);
    for (int i = 4; i < 8; i++) begin tck(i == 7, 8'hA6 >> i); dout[i] = last_tdo; end
    tck(1, 0); tck(0, 0); tck(0, 0);
    check("t5_capture", dout[7:0], 8'h3C);
    check("t5_user_out", user_dr_out, 8'hA6);

    // Five tms=1 edges from ShiftIr land in TestLogicReset via UpdateIr
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
    repeat (5) tck(1, 0);
    check("t5_tms_reset_state", 32'(dut.tap_state), 32'd0);
    check("t5_ir_after_update", ir_value, 4'b0000);
    tck(1, 0);
    check("t5_ir_in_tlr", ir_value, 4'b1110);

    // 6. reset clears user_dr_out; reset mid-ShiftDr aborts without update
    reset = 1'b1; tck(0, 0); reset = 1'b0;
    check("t6_reset_user_out", user_dr_out, 8'h00);
    tck(0, 0);
    load_ir(4'b1010, cap);
    p0 = pulse_cnt;
    user_dr_in = 8'h99;
    tck(1, 0); tck(0, 0); tck(0, 0);
    tck(0, 1); tck(0, 1); tck(0, 1);
    reset = 1'b1; tck(0, 1); reset = 1'b0;
    tck(1, 0); tck(1, 0); tck(1, 0);
    check("t6_state", 32'(dut.tap_state), 32'd0);
    check("t6_user_out", user_dr_out, 8'h00);
    check("t6_ir", ir_value, 4'b1110);
    check("t6_no_pulse", pulse_cnt - p0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
